ext_mem_model: RTL and testbench
================================

Name: ext_mem_model

Overview:
- Behavioural external main memory, 128-bit line-wide. Serves the processor's cache refill and writeback traffic over a tagged request / write-data / response interface.
- Sits outside riscv_top and connects directly to its mem_req_*/mem_resp_* ports.
- Storage is an array named ram, one line per entry. The bench preloads it via $readmemh and checks it by hierarchical reads of ram[line_index].

Parameters:
- ADDR_BITS, 28: line address width (byte address >> 4).
- DATA_BITS, 128: line width.
- TAG_BITS, 5: request tag width.
- RAM_INDEX_BITS, 20: implemented depth 2^RAM_INDEX_BITS lines; upper address bits ignored.
- LATENCY, 4: cycles from read-request accept to response (>=1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 resets on the clock edge).
- mem_req_valid  in  1  request valid.
- mem_req_ready  out  1  request accepted when valid&ready.
- mem_req_rw  in  1  1=write, 0=read.
- mem_req_addr  in  ADDR_BITS  line address.
- mem_req_tag  in  TAG_BITS  tag, echoed on read response.
- mem_req_data_valid  in  1  write data valid.
- mem_req_data_ready  out  1  write data accepted when valid&ready.
- mem_req_data_bits  in  DATA_BITS  write line data.
- mem_req_data_mask  in  DATA_BITS/8  byte enables; bit i covers bits [8i+7:8i].
- mem_resp_valid  out  1  read response valid; no back-pressure.
- mem_resp_tag  out  TAG_BITS  tag of the answered read.
- mem_resp_data  out  DATA_BITS  read line.

Behaviour:
- While reset==0 at a clock edge:
  - FSM goes to IDLE.
  - Response pipeline is cleared, so mem_resp_valid=0, mem_resp_tag=0, mem_resp_data=0 next cycle.
  - ram is NOT cleared; preloaded contents survive reset.
  - In-flight reads and pending writes are dropped, including when reset hits mid-operation.
- FSM states:
  - IDLE: mem_req_ready=1, mem_req_data_ready=0.
  - WDATA: mem_req_ready=0, mem_req_data_ready=1.
- Read accept (IDLE, valid, rw=0):
  - ram[addr[RAM_INDEX_BITS-1:0]] is sampled at the accept edge.
  - {data, tag} enters a LATENCY-deep shift pipeline.
  - mem_resp_valid is high exactly LATENCY cycles after the accept edge, for one cycle per read.
  - Back-to-back reads are accepted every cycle; responses return in order.
- Write accept (IDLE, valid, rw=1):
  - Latch addr, go to WDATA.
  - In WDATA, on data_valid: for each byte i with mask[i]=1, ram[line] byte i <= data byte i; masked-off bytes are unchanged. Return to IDLE.
  - Writes produce no response.
  - Data presented in the same cycle as the write request is ignored; the data beat is only taken in WDATA.
- Ordering:
  - A write commits at its data-accept edge.
  - A read accepted in a later cycle returns the new data.
  - Reads already in the pipeline keep their sampled data.
- Outputs are combinational from the FSM state (ready signals) or registered (resp_*); there are no combinational input-to-output paths.
- Address wrap: an address beyond the implemented depth aliases by truncation.

Decomposition:
- Shared package: MEM_ADDR_BITS=28, MEM_DATA_BITS=128, MEM_TAG_BITS=5, the mask width, and the FSM state enum {IDLE, WDATA}.
- One natural sub-module: mem_resp_pipe, a LATENCY-stage valid/tag/data shift register with synchronous active-low clear.
- ram array, FSM and byte-masked write stay in the top.

Test Plan:
- Reset: hold reset=0 for 3 cycles with preloaded ram[5]=0x0123..EF -> resp_valid=0, mem_req_ready=0 during reset then 1 after; ram[5] unchanged.
- Read latency: read addr=5 tag=3 at cycle N -> resp_valid only at N+4, tag=3, data=0x0123..EF; no extra responses.
- Masked write then read:
  - Write addr=7, data all 0xAA, mask=0x000F, onto ram[7]=0.
  - Bytes 0-3 become 0xAA, the rest stay 0.
  - A subsequent read of addr=7 returns exactly that.
- Write handshake stall:
  - Write request, then hold data_valid=0 for 5 cycles.
  - mem_req_ready=0 and data_ready=1 throughout; a read request offered is not accepted until after the data beat.
- Pipelined reads: reads to addr 1,2,3 on consecutive cycles with tags 1,2,3 -> three consecutive responses in order with matching data/tags.
- Reset mid-read: read accepted, reset=0 two cycles later -> no response ever appears for that tag.

Source files
------------

// File: rtl/ext_mem_model_pkg.sv
// rtl/ext_mem_model_pkg.sv - shared widths, defaults and FSM state type for the external memory model
package ext_mem_model_pkg;

    localparam int MEM_ADDR_BITS      = 28;
    localparam int MEM_DATA_BITS      = 128;
    localparam int MEM_TAG_BITS       = 5;
    localparam int MEM_MASK_BITS      = MEM_DATA_BITS / 8;
    localparam int MEM_RAM_INDEX_BITS = 20;
    localparam int MEM_LATENCY        = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        WDATA = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_resp_pipe.sv
// rtl/mem_resp_pipe.sv - LATENCY-stage valid/tag/data shift register carrying read responses
//
// Ports:
//   clk       in   clock, rising edge
//   resetn    in   synchronous active-low clear of every stage
//   in_valid  in   a read was accepted on this edge
//   in_tag    in   tag of the accepted read
//   in_data   in   line sampled from the memory array on the accept edge
//   out_valid out  response valid, LATENCY cycles after the accept cycle
//   out_tag   out  tag of the response
//   out_data  out  line data of the response
module mem_resp_pipe
    import ext_mem_model_pkg::*;
#(
    parameter int LATENCY   = MEM_LATENCY,
    parameter int TAG_BITS  = MEM_TAG_BITS,
    parameter int DATA_BITS = MEM_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_valid,
    input  logic [TAG_BITS-1:0]  in_tag,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 out_valid,
    output logic [TAG_BITS-1:0]  out_tag,
    output logic [DATA_BITS-1:0] out_data
);

    logic [LATENCY-1:0]                valid_q, valid_d;
    logic [LATENCY-1:0][TAG_BITS-1:0]  tag_q,   tag_d;
    logic [LATENCY-1:0][DATA_BITS-1:0] data_q,  data_d;

    // Empty slots carry zero tag/data so the response outputs are quiet
    // whenever no response is being presented.
    always_comb begin
        valid_d   = valid_q;
        tag_d     = tag_q;
        data_d    = data_q;
        valid_d[0] = in_valid;
        tag_d[0]   = in_valid ? in_tag  : '0;
        data_d[0]  = in_valid ? in_data : '0;
        for (int i = 1; i < LATENCY; i++) begin
            valid_d[i] = valid_q[i-1];
            tag_d[i]   = tag_q[i-1];
            data_d[i]  = data_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_q <= '0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_tag   = tag_q[LATENCY-1];
    assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/ext_mem_model.sv
// rtl/ext_mem_model.sv - behavioural line-wide external memory with tagged reads and byte-masked writes
//
// Ports:
//   clk                 in   clock, rising edge
//   reset               in   synchronous active-low reset
//   mem_req_valid       in   request valid
//   mem_req_ready       out  request accepted when valid & ready (IDLE only)
//   mem_req_rw          in   1 = write, 0 = read
//   mem_req_addr        in   line address, upper bits beyond the array alias
//   mem_req_tag         in   tag echoed on the read response
//   mem_req_data_valid  in   write data beat valid
//   mem_req_data_ready  out  write data accepted when valid & ready (WDATA only)
//   mem_req_data_bits   in   write line data
//   mem_req_data_mask   in   byte enables, bit i covers bits [8i+7:8i]
//   mem_resp_valid      out  read response valid, no back-pressure
//   mem_resp_tag        out  tag of the answered read
//   mem_resp_data       out  read line
module ext_mem_model
    import ext_mem_model_pkg::*;
#(
    parameter int ADDR_BITS      = MEM_ADDR_BITS,
    parameter int DATA_BITS      = MEM_DATA_BITS,
    parameter int TAG_BITS       = MEM_TAG_BITS,
    parameter int RAM_INDEX_BITS = MEM_RAM_INDEX_BITS,
    parameter int LATENCY        = MEM_LATENCY
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mem_req_valid,
    output logic                   mem_req_ready,
    input  logic                   mem_req_rw,
    input  logic [ADDR_BITS-1:0]   mem_req_addr,
    input  logic [TAG_BITS-1:0]    mem_req_tag,
    input  logic                   mem_req_data_valid,
    output logic                   mem_req_data_ready,
    input  logic [DATA_BITS-1:0]   mem_req_data_bits,
    input  logic [DATA_BITS/8-1:0] mem_req_data_mask,
    output logic                   mem_resp_valid,
    output logic [TAG_BITS-1:0]    mem_resp_tag,
    output logic [DATA_BITS-1:0]   mem_resp_data
);

    localparam int MASK_BITS = DATA_BITS / 8;
    localparam int RAM_DEPTH = 1 << RAM_INDEX_BITS;

    logic [DATA_BITS-1:0] ram [RAM_DEPTH];

    mem_state_e                state_q, state_d;
    logic [RAM_INDEX_BITS-1:0] waddr_q, waddr_d;
    // Low while reset is held and for the reset edge itself, so neither
    // handshake is offered until the model is out of reset.
    logic                      live_q, live_d;

    logic [RAM_INDEX_BITS-1:0] req_idx;
    logic                      rd_fire;
    logic                      wr_req_fire;
    logic                      wd_fire;
    logic [DATA_BITS-1:0]      rd_line;
    logic                      unused_addr_hi;

    // Addresses beyond the implemented depth alias by truncation.
    assign req_idx        = mem_req_addr[RAM_INDEX_BITS-1:0];
    assign unused_addr_hi = ^mem_req_addr[ADDR_BITS-1:RAM_INDEX_BITS];

    // Ready signals depend only on registered state.
    assign mem_req_ready      = live_q && (state_q == IDLE);
    assign mem_req_data_ready = live_q && (state_q == WDATA);

    assign rd_fire     = mem_req_valid && mem_req_ready && !mem_req_rw;
    assign wr_req_fire = mem_req_valid && mem_req_ready &&  mem_req_rw;
    assign wd_fire     = mem_req_data_valid && mem_req_data_ready;

    assign rd_line = ram[req_idx];
    assign live_d  = 1'b1;

    always_comb begin
        state_d = state_q;
        waddr_d = waddr_q;
        case (state_q)
            IDLE: begin
                if (wr_req_fire) begin
                    state_d = WDATA;
                    waddr_d = req_idx;
                end
            end
            WDATA: begin
                if (wd_fire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            waddr_q <= '0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            live_q  <= live_d;
        end
    end

    // The array is never cleared so preloaded contents survive reset; a data
    // beat coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (reset && wd_fire) begin
            for (int i = 0; i < MASK_BITS; i++) begin
                if (mem_req_data_mask[i]) begin
                    ram[waddr_q][8*i +: 8] <= mem_req_data_bits[8*i +: 8];
                end
            end
        end
    end

    // The line is sampled on the accept edge, so reads already in flight
    // keep their data even if a later write changes the line.
    mem_resp_pipe #(
        .LATENCY   (LATENCY),
        .TAG_BITS  (TAG_BITS),
        .DATA_BITS (DATA_BITS)
    ) u_resp_pipe (
        .clk       (clk),
        .resetn    (reset),
        .in_valid  (rd_fire),
        .in_tag    (mem_req_tag),
        .in_data   (rd_line),
        .out_valid (mem_resp_valid),
        .out_tag   (mem_resp_tag),
        .out_data  (mem_resp_data)
    );

endmodule

// File: tb/tb_ext_mem_model.sv
// tb/tb_ext_mem_model.sv - directed self-checking bench for ext_mem_model
module tb_ext_mem_model;

    logic         clk;
    logic         reset;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic         mem_req_rw;
    logic [27:0]  mem_req_addr;
    logic [4:0]   mem_req_tag;
    logic         mem_req_data_valid;
    logic         mem_req_data_ready;
    logic [127:0] mem_req_data_bits;
    logic [15:0]  mem_req_data_mask;
    logic         mem_resp_valid;
    logic [4:0]   mem_resp_tag;
    logic [127:0] mem_resp_data;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [127:0] L1 = 128'h1111_0000_0000_0000_0000_0000_0000_0001;
    localparam logic [127:0] L2 = 128'h2222_0000_0000_0000_0000_0000_0000_0002;
    localparam logic [127:0] L3 = 128'h3333_0000_0000_0000_0000_0000_0000_0003;
    localparam logic [127:0] L5 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] L7 = 128'h0000_0000_0000_0000_0000_0000_AAAA_AAAA;
    localparam logic [127:0] L9 = 128'hDEADBEEF_CAFEF00D_00112233_44556677;

    ext_mem_model dut (
        .clk                (clk),
        .reset              (reset),
        .mem_req_valid      (mem_req_valid),
        .mem_req_ready      (mem_req_ready),
        .mem_req_rw         (mem_req_rw),
        .mem_req_addr       (mem_req_addr),
        .mem_req_tag        (mem_req_tag),
        .mem_req_data_valid (mem_req_data_valid),
        .mem_req_data_ready (mem_req_data_ready),
        .mem_req_data_bits  (mem_req_data_bits),
        .mem_req_data_mask  (mem_req_data_mask),
        .mem_resp_valid     (mem_resp_valid),
        .mem_resp_tag       (mem_resp_tag),
        .mem_resp_data      (mem_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    // Offer one read now; expect exactly one response four cycles later.
    task automatic read_expect(input logic [27:0] addr, input logic [4:0] tag, input logic [127:0] exp);
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b0;
        mem_req_addr  = addr;
        mem_req_tag   = tag;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) mem_req_valid = 1'b0;
            check($sformatf("rd_valid_a%0h_c%0d", addr, k), {127'b0, mem_resp_valid}, {127'b0, (k == 4)});
            if (k == 4) begin
                check($sformatf("rd_tag_a%0h", addr), {123'b0, mem_resp_tag}, {123'b0, tag});
                check($sformatf("rd_data_a%0h", addr), mem_resp_data, exp);
            end
        end
    endtask

    initial begin
        reset              = 1'b0;
        mem_req_valid      = 1'b0;
        mem_req_rw         = 1'b0;
        mem_req_addr       = '0;
        mem_req_tag        = '0;
        mem_req_data_valid = 1'b0;
        mem_req_data_bits  = '0;
        mem_req_data_mask  = '0;
        dut.ram[1] = L1;
        dut.ram[2] = L2;
        dut.ram[3] = L3;
        dut.ram[5] = L5;
        dut.ram[7] = '0;
        dut.ram[9] = '0;

        // Reset held for three edges
        repeat (3) tick();
        check("rst_resp_valid", {127'b0, mem_resp_valid}, 128'd0);
        check("rst_resp_tag", {123'b0, mem_resp_tag}, 128'd0);
        check("rst_resp_data", mem_resp_data, 128'd0);
        check("rst_req_ready", {127'b0, mem_req_ready}, 128'd0);
        check("rst_data_ready", {127'b0, mem_req_data_ready}, 128'd0);
        reset = 1'b1;
        tick();
        check("post_rst_req_ready", {127'b0, mem_req_ready}, 128'd1);
        check("post_rst_data_ready", {127'b0, mem_req_data_ready}, 128'd0);
        check("post_rst_ram5", dut.ram[5], L5);

        // Read latency
        read_expect(28'd5, 5'd3, L5);

        // Masked write; the data offered with the request must be ignored
        mem_req_valid      = 1'b1;
        mem_req_rw         = 1'b1;
        mem_req_addr       = 28'd7;
        mem_req_data_valid = 1'b1;
        mem_req_data_bits  = {16{8'h55}};
        mem_req_data_mask  = 16'hFFFF;
        tick();
        mem_req_valid = 1'b0;
        check("wr_req_ready", {127'b0, mem_req_ready}, 128'd0);
        check("wr_data_ready", {127'b0, mem_req_data_ready}, 128'd1);
        check("wr_ram7_untouched", dut.ram[7], 128'd0);
        mem_req_data_bits = {16{8'hAA}};
        mem_req_data_mask = 16'h000F;
        tick();
        mem_req_data_valid = 1'b0;
        check("wr_back_idle", {127'b0, mem_req_ready}, 128'd1);
        check("wr_ram7", dut.ram[7], L7);
        read_expect(28'd7, 5'd9, L7);

        // Write data stall with a read offered meanwhile
        mem_req_valid      = 1'b1;
        mem_req_rw         = 1'b1;
        mem_req_addr       = 28'd9;
        mem_req_data_valid = 1'b0;
        tick();
        mem_req_rw   = 1'b0;
        mem_req_addr = 28'd5;
        mem_req_tag  = 5'd4;
        for (int k = 1; k <= 5; k++) begin
            check($sformatf("stall_req_ready_%0d", k), {127'b0, mem_req_ready}, 128'd0);
            check($sformatf("stall_data_ready_%0d", k), {127'b0, mem_req_data_ready}, 128'd1);
            check($sformatf("stall_resp_valid_%0d", k), {127'b0, mem_resp_valid}, 128'd0);
            tick();
        end
        mem_req_data_valid = 1'b1;
        mem_req_data_bits  = L9;
        mem_req_data_mask  = 16'hFFFF;
        tick();
        mem_req_data_valid = 1'b0;
        check("stall_done_ready", {127'b0, mem_req_ready}, 128'd1);
        check("stall_ram9", dut.ram[9], L9);
        read_expect(28'd5, 5'd4, L5);

        // Address wrap by truncation
        read_expect(28'h0100005, 5'd2, L5);
        read_expect(28'h0F00009, 5'd11, L9);

        // Back-to-back reads
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b0;
        mem_req_addr  = 28'd1;
        mem_req_tag   = 5'd1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k < 3) begin
                mem_req_addr = 28'(k + 1);
                mem_req_tag  = 5'(k + 1);
            end else begin
                mem_req_valid = 1'b0;
            end
            check($sformatf("pipe_valid_%0d", k), {127'b0, mem_resp_valid}, {127'b0, (k >= 4 && k <= 6)});
            if (k == 4) begin
                check("pipe_tag1", {123'b0, mem_resp_tag}, 128'd1);
                check("pipe_data1", mem_resp_data, L1);
            end
            if (k == 5) begin
                check("pipe_tag2", {123'b0, mem_resp_tag}, 128'd2);
                check("pipe_data2", mem_resp_data, L2);
            end
            if (k == 6) begin
                check("pipe_tag3", {123'b0, mem_resp_tag}, 128'd3);
                check("pipe_data3", mem_resp_data, L3);
            end
        end

        // Reset two cycles after a read is accepted drops its response
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b0;
        mem_req_addr  = 28'd5;
        mem_req_tag   = 5'd6;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 1) mem_req_valid = 1'b0;
            if (k == 2) reset = 1'b0;
            if (k == 3) reset = 1'b1;
            check($sformatf("midrst_resp_valid_%0d", k), {127'b0, mem_resp_valid}, 128'd0);
        end
        check("midrst_ram5", dut.ram[5], L5);
        check("midrst_ready", {127'b0, mem_req_ready}, 128'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
